// File: rtl/apb_master_param_pkg.sv
// Shared types and constants for the parametrised APB4 requester.
// State encoding, PPROT bit meanings and default widths.
package apb_master_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W_DEF  = 8;
  localparam int APB_DATA_W_DEF  = 32;
  localparam int TIMEOUT_CYC_DEF = 16;

  localparam logic [2:0] PPROT_PRIV   = 3'b001;
  localparam logic [2:0] PPROT_NONSEC = 3'b010;
  localparam logic [2:0] PPROT_INSTR  = 3'b100;

  function automatic bit valid_data_w(input int w);
    return (w == 8) || (w == 16) || (w == 32);
  endfunction

endpackage

// File: rtl/apb_master_param_if.sv
// Bundle of command, response and APB signals for apb_master_param.
// The master modport is the requester's view; slave is the opposite side.
interface apb_master_param_if
  import apb_master_param_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W_DEF,
  parameter int DATA_W = APB_DATA_W_DEF,
  parameter int STRB_W = DATA_W / 8
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_strb;
  logic [2:0]        req_prot;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [2:0]        pprot;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_master_param_timeout_cnt.sv
// ACCESS-phase watchdog for apb_master_param; exists only when APB_MASTER_TIMEOUT_EN is defined.
// clear loads 1 (the first ACCESS cycle), enable counts up and saturates at TIMEOUT_CYC.
`ifdef APB_MASTER_TIMEOUT_EN
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = CNT_W'(1);
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/apb_master_param.sv
// APB4 requester: valid/ready command in, one outstanding APB transfer, registered response pulse.
// Optional ACCESS watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_param
  import apb_master_param_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W_DEF,
  parameter int DATA_W      = APB_DATA_W_DEF,
  parameter int STRB_W      = DATA_W / 8,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                pclk,
  input  logic                presetn,
  apb_master_param_if.master  bus
);

  if (!valid_data_w(DATA_W)) begin : g_bad_data_w
    $error("apb_master_param: DATA_W must be 8, 16 or 32");
  end
  if (STRB_W != DATA_W / 8) begin : g_bad_strb_w
    $error("apb_master_param: STRB_W must equal DATA_W/8");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("apb_master_param: TIMEOUT_CYC must be at least 2");
  end

  apb_state_e state_q, state_d;

  logic req_ready, accept, complete, abort;

  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic [2:0]        pprot_q, pprot_d;

  // Completion is captured at the finishing edge, then presented one cycle later.
  logic              cmp_vld_q, cmp_vld_d;
  logic [DATA_W-1:0] cmp_rdata_q, cmp_rdata_d;
  logic              cmp_err_q, cmp_err_d;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

`ifdef APB_MASTER_TIMEOUT_EN
  logic to_expired;
  logic cmp_to_q, rsp_to_q;

  apb_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout_cnt (
    .clk     (pclk),
    .rst_n   (presetn),
    .clear   (state_q == ST_SETUP),
    .enable  (state_q == ST_ACCESS),
    .expired (to_expired)
  );

  // A pready arriving on the threshold cycle completes normally.
  assign abort = (state_q == ST_ACCESS) & to_expired & ~bus.pready;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cmp_to_q <= 1'b0;
      rsp_to_q <= 1'b0;
    end else begin
      cmp_to_q <= abort;
      rsp_to_q <= cmp_to_q;
    end
  end

  assign bus.rsp_timeout = rsp_to_q;
`else
  assign abort           = 1'b0;
  assign bus.rsp_timeout = 1'b0;
`endif

  assign complete = (state_q == ST_ACCESS) & bus.pready;
  assign accept   = bus.req_valid & req_ready;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (abort)            state_d = ST_IDLE;
        else if (bus.pready)  state_d = accept ? ST_SETUP : ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE) |
                ((state_q == ST_ACCESS) & bus.pready & ~abort);

    psel_d    = (state_d != ST_IDLE);
    penable_d = (state_d == ST_ACCESS);
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pprot_d   = pprot_q;
    if (accept) begin
      paddr_d  = bus.req_addr;
      pwrite_d = bus.req_write;
      pwdata_d = bus.req_write ? bus.req_wdata : '0;
      pstrb_d  = bus.req_write ? bus.req_strb  : '0;
      pprot_d  = bus.req_prot;
    end else if (state_d == ST_IDLE) begin
      paddr_d  = '0;
      pwrite_d = 1'b0;
      pwdata_d = '0;
      pstrb_d  = '0;
      pprot_d  = '0;
    end

    cmp_vld_d   = complete | abort;
    cmp_rdata_d = (complete & ~pwrite_q) ? bus.prdata : '0;
    cmp_err_d   = (complete & bus.pslverr) | abort;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_rdata_q <= '0;
      cmp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_rdata_q <= cmp_rdata_d;
      cmp_err_q   <= cmp_err_d;
      rsp_valid_q <= cmp_vld_q;
      rsp_rdata_q <= cmp_rdata_q;
      rsp_err_q   <= cmp_err_q;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.pprot     = pprot_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_param.sv
// Directed bench for apb_master_param: writes, wait-state read, back-to-back, slave error,
// watchdog (or indefinite wait in the default build) and asynchronous reset mid-transfer.
module tb_apb_master_param;
  import apb_master_param_pkg::*;

  logic pclk = 1'b0;
  logic presetn;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 pclk = ~pclk;

  apb_master_param_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  apb_master_param #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_strb  = strb;
    bus.req_prot  = prot;
  endtask

  initial begin
    presetn       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.req_prot  = '0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_psel",    bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_paddr",   bus.paddr, 0);
    chk("rst_pwrite",  bus.pwrite, 0);
    chk("rst_pwdata",  bus.pwdata, 0);
    chk("rst_pstrb",   bus.pstrb, 0);
    chk("rst_pprot",   bus.pprot, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err",   bus.rsp_err, 0);
    chk("rst_rsp_to",    bus.rsp_timeout, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    presetn = 1'b1;
    tick();

    // Single write, zero wait states
    issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, PPROT_PRIV);
    bus.pready = 1'b1;
    #1 chk("w1_ready_idle", bus.req_ready, 1);
    tick();                                     // edge k: accept
    bus.req_valid = 1'b0;
    chk("w1_setup_psel",    bus.psel, 1);
    chk("w1_setup_penable", bus.penable, 0);
    chk("w1_paddr",  bus.paddr, 8'h10);
    chk("w1_pwrite", bus.pwrite, 1);
    chk("w1_pwdata", bus.pwdata, 32'hDEADBEEF);
    chk("w1_pstrb",  bus.pstrb, 4'hF);
    chk("w1_pprot",  bus.pprot, 3'b001);
    chk("w1_setup_ready", bus.req_ready, 0);
    tick();                                     // k+1: ACCESS
    chk("w1_acc_psel",    bus.psel, 1);
    chk("w1_acc_penable", bus.penable, 1);
    chk("w1_acc_ready",   bus.req_ready, 1);
    chk("w1_acc_rspv",    bus.rsp_valid, 0);
    tick();                                     // k+2: completes
    bus.pready = 1'b0;
    chk("w1_done_psel",  bus.psel, 0);
    chk("w1_done_paddr", bus.paddr, 0);
    chk("w1_done_rspv",  bus.rsp_valid, 0);
    tick();                                     // k+3: response
    chk("w1_rspv",  bus.rsp_valid, 1);
    chk("w1_err",   bus.rsp_err, 0);
    chk("w1_rdata", bus.rsp_rdata, 0);
    tick();
    chk("w1_rspv_pulse", bus.rsp_valid, 0);

    // Read with three wait states
    issue(1'b0, 8'h04, 32'hFFFFFFFF, 4'hF, 3'b000);
    tick();                                     // k: SETUP
    bus.req_valid = 1'b0;
    chk("r1_pwrite", bus.pwrite, 0);
    chk("r1_pstrb",  bus.pstrb, 0);
    chk("r1_pwdata", bus.pwdata, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("r1_acc%0d_penable", i), bus.penable, 1);
      chk($sformatf("r1_acc%0d_paddr", i),   bus.paddr, 8'h04);
      if (i < 4) begin
        chk($sformatf("r1_acc%0d_ready", i), bus.req_ready, 0);
      end else begin
        bus.pready = 1'b1;
        bus.prdata = 32'h12345678;
        #1 chk("r1_acc4_ready", bus.req_ready, 1);
      end
    end
    tick();                                     // completing edge
    bus.pready = 1'b0;
    bus.prdata = 32'h0;
    chk("r1_done_psel", bus.psel, 0);
    chk("r1_done_rspv", bus.rsp_valid, 0);
    tick();
    chk("r1_rspv",  bus.rsp_valid, 1);
    chk("r1_rdata", bus.rsp_rdata, 32'h12345678);
    chk("r1_err",   bus.rsp_err, 0);
    tick();

    // Back-to-back writes
    bus.pready = 1'b1;
    issue(1'b1, 8'h20, 32'h11111111, 4'h3, 3'b000);
    tick();                                     // k: SETUP A
    issue(1'b1, 8'h24, 32'h22222222, 4'hC, 3'b000);
    chk("bb_a_setup_penable", bus.penable, 0);
    chk("bb_a_paddr", bus.paddr, 8'h20);
    tick();                                     // k+1: ACCESS A
    chk("bb_a_acc_penable", bus.penable, 1);
    chk("bb_a_acc_ready",   bus.req_ready, 1);
    tick();                                     // k+2: A done, SETUP B
    bus.req_valid = 1'b0;
    chk("bb_b_setup_psel",    bus.psel, 1);
    chk("bb_b_setup_penable", bus.penable, 0);
    chk("bb_b_paddr",  bus.paddr, 8'h24);
    chk("bb_b_pwdata", bus.pwdata, 32'h22222222);
    chk("bb_b_pstrb",  bus.pstrb, 4'hC);
    tick();                                     // k+3: ACCESS B, rsp A
    chk("bb_b_acc_psel",    bus.psel, 1);
    chk("bb_b_acc_penable", bus.penable, 1);
    chk("bb_rsp_a", bus.rsp_valid, 1);
    tick();                                     // k+4: B done
    bus.pready = 1'b0;
    chk("bb_idle_psel", bus.psel, 0);
    chk("bb_gap_rspv",  bus.rsp_valid, 0);
    tick();
    chk("bb_rsp_b", bus.rsp_valid, 1);
    tick();
    chk("bb_rsp_b_pulse", bus.rsp_valid, 0);

    // Read with slave error
    issue(1'b0, 8'h08, 32'h0, 4'hF, PPROT_NONSEC | PPROT_INSTR);
    bus.pready  = 1'b1;
    bus.pslverr = 1'b1;
    bus.prdata  = 32'hCAFEF00D;
    tick();
    bus.req_valid = 1'b0;
    chk("err_pstrb", bus.pstrb, 0);
    chk("err_pprot", bus.pprot, 3'b110);
    tick();
    tick();
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    tick();
    chk("err_rspv",  bus.rsp_valid, 1);
    chk("err_err",   bus.rsp_err, 1);
    chk("err_to",    bus.rsp_timeout, 0);
    chk("err_rdata", bus.rsp_rdata, 32'hCAFEF00D);
    tick();

    // Slave never ready
    issue(1'b0, 8'h30, 32'h0, 4'h0, 3'b000);
    bus.prdata = 32'hA5A5A5A5;
    tick();                                     // SETUP
    bus.req_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("to_acc%0d_penable", i), bus.penable, 1);
    end
    chk("to_abort_ready", bus.req_ready, 0);
    tick();
    chk("to_idle_psel", bus.psel, 0);
    chk("to_idle_penable", bus.penable, 0);
    tick();
    chk("to_rspv",  bus.rsp_valid, 1);
    chk("to_err",   bus.rsp_err, 1);
    chk("to_to",    bus.rsp_timeout, 1);
    chk("to_rdata", bus.rsp_rdata, 0);
    tick();
    chk("to_rspv_pulse", bus.rsp_valid, 0);
`else
    for (int i = 1; i <= 20; i++) tick();
    chk("wait_psel",    bus.psel, 1);
    chk("wait_penable", bus.penable, 1);
    chk("wait_rspv",    bus.rsp_valid, 0);
    bus.pready = 1'b1;
    tick();
    bus.pready = 1'b0;
    tick();
    chk("wait_rspv_done", bus.rsp_valid, 1);
    chk("wait_rdata",     bus.rsp_rdata, 32'hA5A5A5A5);
    chk("wait_to",        bus.rsp_timeout, 0);
    tick();
`endif
    bus.prdata = 32'h0;

    // Asynchronous reset during an ACCESS wait
    issue(1'b0, 8'h40, 32'h0, 4'h0, 3'b000);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("ar_pre_penable", bus.penable, 1);
    #2 presetn = 1'b0;
    #1;
    chk("ar_psel",    bus.psel, 0);
    chk("ar_penable", bus.penable, 0);
    chk("ar_paddr",   bus.paddr, 0);
    chk("ar_rspv",    bus.rsp_valid, 0);
    tick();
    presetn = 1'b1;
    tick();
    chk("ar_no_rsp", bus.rsp_valid, 0);
    issue(1'b1, 8'h44, 32'h0BADCAFE, 4'h5, 3'b000);
    bus.pready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("ar_w_paddr", bus.paddr, 8'h44);
    chk("ar_w_pstrb", bus.pstrb, 4'h5);
    tick();
    tick();
    bus.pready = 1'b0;
    tick();
    chk("ar_w_rspv", bus.rsp_valid, 1);
    chk("ar_w_err",  bus.rsp_err, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
